lcd_refresh_ctrl: RTL

//  Drives the DE2 16x2 HD44780 character LCD from the combinational string table
//  (index -> 8-bit char). Powers up and initialises the panel, then refreshes

---
 rtl/lcd_refresh_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 LCD driver: power-up wait, 5-command init, then endless refresh of both lines.
// All outputs are registered; every byte is LOAD, SETUP, EN_HI, HOLD, WAIT timed purely by counters.
module lcd_refresh_ctrl #(
  parameter int POWERUP_CYC    = 1_000_000,
  parameter int EN_HIGH_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2_500,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic       frame_done
);

  localparam int MAX_AB  = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int MAX_CD  = (EN_HIGH_CYC > CMD_WAIT_CYC) ? EN_HIGH_CYC : CMD_WAIT_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {PWRUP, INIT, ADDR1, CHARS1, ADDR2, CHARS2} phase_t;
  typedef enum logic [2:0] {LOAD, SETUP, EN_HI, HOLD, WAIT} step_t;

  phase_t      phase_q, phase_d;
  step_t       step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  item_q, item_d;
  logic [4:0]  index_q, index_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_en_q, lcd_en_d;
  logic        lcd_on_q, lcd_on_d;
  logic        frame_done_q, frame_done_d;

  logic [7:0]    mapped_char;
  logic [7:0]    init_cmd;
  logic [CW-1:0] wait_last;

  // Raw nibble values from the table become printable hex digits.
  always_comb begin
    if (char_in < 8'h0A)      mapped_char = char_in + 8'h30;
    else if (char_in < 8'h10) mapped_char = char_in + 8'h37;
    else                      mapped_char = char_in;
  end

  always_comb begin
    case (item_q)
      4'd0, 4'd1: init_cmd = 8'h38;
      4'd2:       init_cmd = 8'h0C;
      4'd3:       init_cmd = 8'h01;
      default:    init_cmd = 8'h06;
    endcase
  end

  // The clear command needs the long settle time; everything else the short one.
  assign wait_last = (!lcd_rs_q && lcd_data_q == 8'h01) ? CW'(CLEAR_WAIT_CYC - 1)
                                                        : CW'(CMD_WAIT_CYC - 1);

  always_comb begin
    phase_d      = phase_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    item_d       = item_q;
    index_d      = index_q;
    lcd_data_d   = lcd_data_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_en_d     = 1'b0;
    lcd_on_d     = 1'b1;
    frame_done_d = 1'b0;
    if (phase_q == PWRUP) begin
      if (cnt_q == CW'(POWERUP_CYC - 1)) begin
        phase_d = INIT;
        step_d  = LOAD;
        item_d  = 4'd0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      case (step_q)
        LOAD: begin
          step_d = SETUP;
          case (phase_q)
            INIT:    begin lcd_data_d = init_cmd;    lcd_rs_d = 1'b0; end
            ADDR1:   begin lcd_data_d = 8'h80;       lcd_rs_d = 1'b0; end
            ADDR2:   begin lcd_data_d = 8'hC0;       lcd_rs_d = 1'b0; end
            default: begin lcd_data_d = mapped_char; lcd_rs_d = 1'b1; end
          endcase
        end
        SETUP: begin
          step_d   = EN_HI;
          lcd_en_d = 1'b1;
          cnt_d    = '0;
        end
        EN_HI: begin
          if (cnt_q == CW'(EN_HIGH_CYC - 1)) begin
            step_d = HOLD;
            cnt_d  = '0;
          end else begin
            lcd_en_d = 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          step_d = WAIT;
          cnt_d  = '0;
        end
        default: begin
          if (cnt_q == wait_last) begin
            step_d = LOAD;
            cnt_d  = '0;
            item_d = item_q + 4'd1;
            case (phase_q)
              INIT: if (item_q == 4'd4) begin phase_d = ADDR1; item_d = 4'd0; end
              ADDR1: begin phase_d = CHARS1; item_d = 4'd0; index_d = 5'h00; end
              CHARS1: begin
                if (item_q == 4'd15) begin phase_d = ADDR2; item_d = 4'd0; end
                else index_d = index_q + 5'd1;
              end
              ADDR2: begin phase_d = CHARS2; item_d = 4'd0; index_d = 5'h10; end
              default: begin
                if (item_q == 4'd15) begin
                  phase_d      = ADDR1;
                  item_d       = 4'd0;
                  frame_done_d = 1'b1;
                end else begin
                  index_d = index_q + 5'd1;
                end
              end
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= PWRUP;
      step_q       <= LOAD;
      cnt_q        <= '0;
      item_q       <= 4'd0;
      index_q      <= 5'd0;
      lcd_data_q   <= 8'h00;
      lcd_rs_q     <= 1'b0;
      lcd_en_q     <= 1'b0;
      lcd_on_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      item_q       <= item_d;
      index_q      <= index_d;
      lcd_data_q   <= lcd_data_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_en_q     <= lcd_en_d;
      lcd_on_q     <= lcd_on_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign index      = index_q;
  assign lcd_data   = lcd_data_q;
  assign lcd_rs     = lcd_rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = lcd_en_q;
  assign lcd_on     = lcd_on_q;
  assign lcd_blon   = lcd_on_q;
  assign frame_done = frame_done_q;

endmodule
